// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encoding, watchdog
// default and the hard-wired zero register number.
package pipe_ctrl_pkg;

    // RUN: pipe flowing; WAIT: frozen behind a data-memory access.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Memory-wait cycles tolerated before the watchdog trips.
    localparam int MAX_WAIT_DEF = 16;

    // $zero is never written, so it can never create a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Purely combinational so the
// forwarding unit can share it.
module pipe_hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rs,
    input  logic       i_id_uses_rt,
    input  logic [4:0] i_ex_rt,
    input  logic       i_ex_memtoreg,
    output logic       o_load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit   = i_id_uses_rs & (i_id_rs == i_ex_rt);
    assign w_rt_hit   = i_id_uses_rt & (i_id_rt == i_ex_rt);
    assign o_load_use = i_ex_memtoreg & (i_ex_rt != REG_ZERO) & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage MIPS core: freezes on memory waits,
// flushes on taken branches, stalls on load-use hazards, and watches memory
// waits with a sticky timeout.
// Optional feature macro: PIPE_CTRL_PERF_EN builds the stall/flush counters;
// without it both counter outputs are tied to zero.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_memtoreg,
    input  logic        ex_branch,
    input  logic        ex_zero,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_flush,
    output logic        pc_sel,
    output logic        mem_timeout,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_e     r_state;
    state_e     w_next_state;
    logic [7:0] r_wait_cnt;
    logic       r_timeout;
    logic       w_br_taken;
    logic       w_load_use;
    logic       w_mem_busy;

    assign w_br_taken = ex_branch & ex_zero;
    assign w_mem_busy = mem_req & ~mem_ready;

    pipe_hazard_cmp u_hazard_cmp (
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_uses_rs  (id_uses_rs),
        .i_id_uses_rt  (id_uses_rt),
        .i_ex_rt       (ex_rt),
        .i_ex_memtoreg (ex_memtoreg),
        .o_load_use    (w_load_use)
    );

    // State register; reset drops any pending wait straight back to RUN.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus Mealy pipeline controls, priority busy > branch > load-use.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_flush  = 1'b0;
        pc_sel       = 1'b0;

        case (r_state)
            ST_RUN:  if (w_mem_busy) w_next_state = ST_WAIT;
            ST_WAIT: if (mem_ready || !mem_req) w_next_state = ST_RUN;
            default: w_next_state = ST_RUN;
        endcase

        if (w_mem_busy) begin
            // Freeze everything upstream of MEM; WB receives a bubble.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (w_br_taken) begin
            // Redirect fetch and squash the two wrong-path instructions.
            pc_sel      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (w_load_use) begin
            // Hold IF/ID one cycle and bubble EX while the load moves to MEM.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    // Watchdog: count busy cycles spent in WAIT, saturate, trip sticky timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else if (r_state == ST_WAIT && w_mem_busy) begin
            if (r_wait_cnt < MAX_WAIT_C) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (r_wait_cnt >= MAX_WAIT_C - 8'd1) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    assign mem_timeout = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Performance counters: cycles with PC held, cycles with IF/ID squashed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (!pc_en)     r_stall_cnt <= r_stall_cnt + 32'd1;
            if (ifid_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the stimulus process drives inputs just
// after posedge and pushes the expected outputs from a behavioural model;
// the monitor pops and compares at every negedge.
module tb_pipe_ctrl;

    localparam int TB_MAX_WAIT = 4;

    typedef struct {
        logic        pc_en;
        logic        ifid_en;
        logic        idex_en;
        logic        exmem_en;
        logic        ifid_flush;
        logic        idex_flush;
        logic        memwb_flush;
        logic        pc_sel;
        logic        timeout;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        id_uses_rs = 0, id_uses_rt = 0, ex_memtoreg = 0;
    logic        ex_branch = 0, ex_zero = 0, mem_req = 0, mem_ready = 0;
    logic        pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, memwb_flush, pc_sel, mem_timeout;
    logic [31:0] stall_cnt, flush_cnt;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state: length of the current run of busy cycles.
    int          m_streak = 0;
    bit          m_timeout = 0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_flush = 0;

    pipe_ctrl #(.MAX_WAIT(TB_MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rt(ex_rt), .ex_memtoreg(ex_memtoreg),
        .ex_branch(ex_branch), .ex_zero(ex_zero),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .pc_sel(pc_sel), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus: drive, predict, push, then advance the model.
    task automatic cycle(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] ert,
                         input logic m2r, input logic br, input logic zr,
                         input logic req, input logic rdy);
        exp_t e;
        bit   busy, taken, hazard;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_rt = ert; ex_memtoreg = m2r; ex_branch = br; ex_zero = zr;
        mem_req = req; mem_ready = rdy;

        if (r) begin
            m_streak = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
        end

        busy   = req && !rdy;
        taken  = br && zr;
        hazard = m2r && (ert != 0) && ((urs && rs == ert) || (urt && rt == ert));

        e = '{pc_en: 1, ifid_en: 1, idex_en: 1, exmem_en: 1, ifid_flush: 0,
              idex_flush: 0, memwb_flush: 0, pc_sel: 0, timeout: m_timeout,
              stall: 0, flush: 0};
        if (busy) begin
            e.pc_en = 0; e.ifid_en = 0; e.idex_en = 0; e.exmem_en = 0; e.memwb_flush = 1;
        end else if (taken) begin
            e.pc_sel = 1; e.ifid_flush = 1; e.idex_flush = 1;
        end else if (hazard) begin
            e.pc_en = 0; e.ifid_en = 0; e.idex_flush = 1;
        end
`ifdef PIPE_CTRL_PERF_EN
        e.stall = m_stall;
        e.flush = m_flush;
`endif
        sb_q.push_back(e);

        if (!r) begin
            // The first busy cycle is spent in RUN; each further one is a wait cycle.
            m_streak = busy ? m_streak + 1 : 0;
            if (m_streak > TB_MAX_WAIT) m_timeout = 1;
            if (!e.pc_en)     m_stall = m_stall + 1;
            if (e.ifid_flush) m_flush = m_flush + 1;
        end
    endtask

    task automatic idle(input logic r);
        cycle(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle; compare at the negedge capture point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pc_en",       32'(pc_en),       32'(e.pc_en));
                check("ifid_en",     32'(ifid_en),     32'(e.ifid_en));
                check("idex_en",     32'(idex_en),     32'(e.idex_en));
                check("exmem_en",    32'(exmem_en),    32'(e.exmem_en));
                check("ifid_flush",  32'(ifid_flush),  32'(e.ifid_flush));
                check("idex_flush",  32'(idex_flush),  32'(e.idex_flush));
                check("memwb_flush", 32'(memwb_flush), 32'(e.memwb_flush));
                check("pc_sel",      32'(pc_sel),      32'(e.pc_sel));
                check("mem_timeout", 32'(mem_timeout), 32'(e.timeout));
                check("stall_cnt",   stall_cnt,        e.stall);
                check("flush_cnt",   flush_cnt,        e.flush);
            end
        end
    end

    initial begin
        // Reset with all inputs low.
        idle(1); idle(1); idle(0);

        // Load-use on rs, then the pipe flows again.
        cycle(0, 2, 7, 1, 0, 2, 1, 0, 0, 0, 0);
        idle(0);
        // Load-use on rt.
        cycle(0, 9, 3, 0, 1, 3, 1, 0, 0, 0, 0);
        // Load to $zero never stalls.
        cycle(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        // Register matches but the source is not used.
        cycle(0, 5, 5, 0, 0, 5, 1, 0, 0, 0, 0);
        // Taken branch, then branch not taken.
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Memory ready in the same cycle as the request: no stall.
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // Three busy cycles, then ready.
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(0);
        // Busy, branch and load-use together: freeze only; branch taken when ready.
        repeat (2) cycle(0, 4, 0, 1, 0, 4, 1, 1, 1, 1, 0);
        cycle(0, 4, 0, 1, 0, 4, 1, 1, 1, 1, 1);
        // Request dropped while waiting returns to RUN.
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Watchdog: hold mem_ready low past MAX_WAIT; timeout is sticky.
        repeat (TB_MAX_WAIT + 4) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) idle(0);
        // Reset asserted mid-WAIT clears the timeout; counting restarts from RUN.
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (TB_MAX_WAIT + 2) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        idle(0);

        // Randomized traffic with small register ranges so hazards are common.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) == 0), 1'($urandom));
        end
        idle(0);

        // Let the monitor drain the final expectation.
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller for the 5-stage MIPS core. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC: it stalls on load-use hazards, flushes on taken branches, and freezes the pipe while data memory is busy. It sits beside the ID/EX register and drives its enable and bubble inputs every cycle. It also keeps a watchdog on memory waits and optional stall/flush performance counters.

## Interface
Parameters:
- MAX_WAIT, 16: memory-wait cycles tolerated before `mem_timeout` sets; range 1..255.

Ports:
- clk  in  1  core clock. State updates on posedge; pipeline registers capture on negedge.
- rst  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt.
- ex_rt  in  5  destination register of the instruction in EX (rt_out of ID/EX).
- ex_memtoreg  in  1  EX instruction is a load (MemtoReg_out).
- ex_branch, ex_zero  in  1 each  EX branch flag and ALU zero.
- mem_req  in  1  MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes this cycle.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble, all controls zeroed.
- pc_sel  out  1  1 = PC loads branch target.
- mem_timeout  out  1  sticky watchdog error.
- stall_cnt, flush_cnt  out  32 each  performance counters.

## Operation
- Definitions:
  - `br_taken = ex_branch & ex_zero`.
  - `load_use = ex_memtoreg & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt))`.
  - `mem_busy = mem_req & ~mem_ready`.
- FSM states: RUN, WAIT.
  - RUN→WAIT when `mem_busy`.
  - WAIT→RUN when `mem_ready`, or when `mem_req` drops.
- Priority per cycle: `mem_busy` > `br_taken` > `load_use` > normal.
- `mem_busy` (in either state):
  - pc_en, ifid_en, idex_en and exmem_en are 0.
  - memwb_flush is 1.
  - All other flushes are 0 and pc_sel is 0.
- `br_taken` (without `mem_busy`):
  - pc_en=1, pc_sel=1.
  - ifid_flush=1, idex_flush=1.
  - All enables are 1.
- `load_use` only:
  - pc_en=0, ifid_en=0.
  - idex_flush=1.
  - exmem_en=1.
  - Lasts exactly one cycle, because the load advances to MEM.
- Normal: all enables 1, all flushes 0, pc_sel 0.
- Flush has precedence over enable for the same register.
- Watchdog:
  - An 8-bit wait counter increments each cycle in WAIT with `mem_busy`, and clears on leaving WAIT.
  - When it reaches MAX_WAIT, `mem_timeout` sets and stays set until `rst`.
  - The counter saturates at MAX_WAIT.

## Timing
- All pipeline-control outputs are combinational (Mealy) from inputs and state. They must settle within the first half-cycle, before the negedge capture.
- `mem_timeout` and the counters are registered on posedge.
- Reset values:
  - State RUN, wait counter 0.
  - mem_timeout 0, stall_cnt 0, flush_cnt 0.
  - Combinational outputs follow the inputs; with all inputs 0 they take the normal values.
- Reset asserted mid-WAIT: return to RUN immediately and clear the watchdog. A pending memory access is the memory's responsibility.
- `mem_ready` arriving in the same cycle as `mem_req`: no stall, state stays RUN.
- Branch and load-use in the same cycle: the branch wins. The load-dependent instruction is flushed, so no stall is needed.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - stall_cnt increments in every cycle where pc_en=0.
  - flush_cnt increments in every cycle where ifid_flush=1.
  - Both are 32-bit and wrap modulo 2^32.
- Not defined: the counter logic is not built and both outputs are tied to 32'd0.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - state encoding (RUN=1'b0, WAIT=1'b1);
  - MAX_WAIT default;
  - register-zero constant 5'd0.
- One sub-module, `pipe_hazard_cmp`: combinational load-use comparator producing `load_use`. It is reused by the forwarding unit later.

## Test plan
- lw $2 in EX (ex_rt=2, ex_memtoreg=1), ID reads rs=2 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1.
- Same as above but ex_rt=0 → no stall.
- ex_branch=1, ex_zero=1 → pc_sel=1, ifid_flush=1, idex_flush=1 for one cycle; flush_cnt +1 when `PIPE_CTRL_PERF_EN` is defined.
- mem_req=1, mem_ready=0 for 3 cycles, then 1 → enables 0 and memwb_flush=1 for 3 cycles; stall_cnt=3; RUN on the 4th cycle.
- MAX_WAIT=4, mem_ready held 0 → mem_timeout=1 after the 4th wait cycle and stays 1; `rst` pulse clears it and returns the FSM to RUN.
- mem_busy, br_taken and load_use all in the same cycle → freeze only (pc_sel=0, ifid_flush=0); the branch flush occurs in the cycle mem_ready=1.
